multicycle_sequencer: RTL and testbench

- Control FSM that sequences a multi-cycle RV32I datapath. The datapath shares one memory port between instruction fetch and load/store.
- Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and issues the write-enable and memory strobes. The existing opcode/funct decoder keeps producing the mux selects and ALU control.
- Has a memory-wait watchdog, a sticky trap for illegal opcodes and timeouts, and a retired-instruction counter.

---
 rtl/multicycle_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Control FSM for a multi-cycle RV32I datapath sharing one memory port between
// fetch and load/store: sequences FETCH/DECODE/EXECUTE/MEM/WB with a watchdog and sticky trap.
module multicycle_sequencer #(
    parameter int TIMEOUT   = 255,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_src,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 reg_we,
    output logic                 instr_retired,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    state_t               state_r;
    state_t               next_s;
    logic [CNT_W-1:0]     wait_cnt_r;
    logic                 trap_r;
    logic [INSTRET_W-1:0] instret_r;

    logic mem_req_s;
    logic mem_we_s;
    logic addr_src_s;
    logic ir_we_s;
    logic pc_we_s;
    logic reg_we_s;
    logic retired_s;
    logic waiting_s;

    function automatic logic is_legal(input logic [6:0] opc);
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    // Stores and branches are the only legal opcodes without a destination register.
    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OP_STORE, OP_BRANCH: writes_rd = 1'b0;
            default:             writes_rd = is_legal(opc);
        endcase
    endfunction

    // Next-state and strobe decode; memory-access states are Mealy on mem_ready.
    always_comb begin
        next_s     = state_r;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_src_s = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        reg_we_s   = 1'b0;
        retired_s  = 1'b0;
        waiting_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s = 1'b1;
                    next_s  = S_DECODE;
                end else if (wait_cnt_r == WAIT_LIMIT) begin
                    next_s = S_TRAP;
                end else begin
                    waiting_s = 1'b1;
                    next_s    = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_legal(op)) begin
                    next_s = S_EXECUTE;
                end else begin
                    next_s = S_TRAP;
                end
            end
            S_EXECUTE: begin
                if ((op == OP_LOAD) || (op == OP_STORE)) begin
                    next_s = S_MEM;
                end else begin
                    next_s = S_WB;
                end
            end
            S_MEM: begin
                mem_req_s  = 1'b1;
                addr_src_s = 1'b1;
                mem_we_s   = (op == OP_STORE);
                if (mem_ready) begin
                    next_s = S_WB;
                end else if (wait_cnt_r == WAIT_LIMIT) begin
                    next_s = S_TRAP;
                end else begin
                    waiting_s = 1'b1;
                    next_s    = S_MEM;
                end
            end
            S_WB: begin
                pc_we_s   = 1'b1;
                retired_s = 1'b1;
                reg_we_s  = writes_rd(op);
                next_s    = S_FETCH;
            end
            S_TRAP: begin
                next_s = S_TRAP;
            end
            default: begin
                next_s = S_TRAP;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Memory-wait watchdog: restarts on entry to each access, counts only unanswered cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((next_s == S_FETCH && state_r != S_FETCH) ||
                     (next_s == S_MEM && state_r != S_MEM)) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (waiting_s) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky trap flag, set on the edge that enters TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_r <= 1'b0;
        end else if (next_s == S_TRAP) begin
            trap_r <= 1'b1;
        end else begin
            trap_r <= trap_r;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retired_s) begin
            instret_r <= instret_r + INSTRET_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Strobes are suppressed combinationally so none survives into a reset cycle.
    assign mem_req       = mem_req_s & ~reset;
    assign mem_we        = mem_we_s & ~reset;
    assign ir_we         = ir_we_s & ~reset;
    assign pc_we         = pc_we_s & ~reset;
    assign reg_we        = reg_we_s & ~reset;
    assign instr_retired = retired_s & ~reset;
    assign addr_src      = addr_src_s;
    assign trap          = trap_r;
    assign state         = state_r;
    assign instret       = instret_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: each instruction is expanded from its opcode and planned
// wait counts into an expected per-cycle trace, then replayed against the DUT.
module tb_multicycle_sequencer;

    localparam int TIMEOUT   = 4;
    localparam int INSTRET_W = 4;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                             7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                             7'b0110011};
    // {state, mem_req, mem_we, addr_src, ir_we, pc_we, reg_we, instr_retired, trap}
    localparam logic [10:0] STROBES = 11'b000_1101_1110;

    typedef struct packed {
        logic [6:0]  op;
        logic        rdy;
        logic [10:0] exp;
    } step_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [6:0]           op = OP_ADDI;
    logic                 mem_ready = 1'b1;
    logic                 mem_req, mem_we, addr_src, ir_we, pc_we, reg_we, instr_retired, trap;
    logic [2:0]           state;
    logic [INSTRET_W-1:0] instret;
    logic [10:0]          obs;

    int    n_checks = 0;
    int    n_fail = 0;
    int    exp_retired = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT(TIMEOUT), .INSTRET_W(INSTRET_W)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_we(ir_we),
        .pc_we(pc_we), .reg_we(reg_we), .instr_retired(instr_retired), .trap(trap),
        .state(state), .instret(instret)
    );

    assign obs = {state, mem_req, mem_we, addr_src, ir_we, pc_we, reg_we, instr_retired, trap};

    function automatic logic is_legal_op(input logic [6:0] o);
        is_legal_op = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (LEGAL_OPS[i] == o) is_legal_op = 1'b1;
        end
    endfunction

    function automatic logic [INSTRET_W-1:0] exp_instret();
        return INSTRET_W'(exp_retired % (1 << INSTRET_W));
    endfunction

    function automatic void push(input logic [6:0] o, input logic r, input logic [10:0] e);
        step_t s;
        s.op = o; s.rdy = r; s.exp = e;
        q.push_back(s);
    endfunction

    task automatic push_trap(input logic [6:0] o);
        for (int i = 0; i < 20; i++) push(o, 1'($urandom), {3'd5, 8'b0000_0001});
    endtask

    // Expected trace of one instruction given its fetch and memory wait counts.
    task automatic plan(input logic [6:0] o, input int fw, input int mw);
        logic st, mem, rw;
        st  = (o == OP_STORE);
        mem = st || (o == OP_LOAD);
        rw  = !(st || (o == OP_BRANCH));
        for (int i = 0; i < fw && i < TIMEOUT; i++) push(o, 1'b0, {3'd0, 8'b1000_0000});
        if (fw >= TIMEOUT) begin
            push_trap(o);
        end else begin
            push(o, 1'b1, {3'd0, 8'b1001_0000});
            push(o, 1'($urandom), {3'd1, 8'b0000_0000});
            if (!is_legal_op(o)) begin
                push_trap(o);
            end else begin
                push(o, 1'($urandom), {3'd2, 8'b0000_0000});
                if (mem) begin
                    for (int i = 0; i < mw && i < TIMEOUT; i++)
                        push(o, 1'b0, {3'd3, 1'b1, st, 1'b1, 5'b0_0000});
                end
                if (mem && mw >= TIMEOUT) begin
                    push_trap(o);
                end else begin
                    if (mem) push(o, 1'b1, {3'd3, 1'b1, st, 1'b1, 5'b0_0000});
                    push(o, 1'($urandom), {3'd4, 4'b0000, 1'b1, rw, 1'b1, 1'b0});
                    exp_retired++;
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_retired = 0;
        q.delete();
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ((obs & STROBES) !== 11'd0 || state !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_hold got=%b exp_state=0 strobes=0", obs);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (state !== 3'd0 || trap !== 1'b0 || instret !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state state=%0d trap=%b instret=%0d exp 0/0/0", state, trap, instret);
        end
    endtask

    task automatic test_addi();
        plan(OP_ADDI, 0, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL addi_step got=%b exp=%b", obs, s.exp); end
        end
        @(posedge clk); #1;
        n_checks++;
        if (instret !== exp_instret()) begin
            n_fail++; $display("FAIL addi_instret got=%0d exp=%0d", instret, exp_instret());
        end
    endtask

    task automatic test_load();
        plan(OP_LOAD, 3, 2);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL load_step got=%b exp=%b", obs, s.exp); end
        end
        @(posedge clk); #1;
        n_checks++;
        if (instret !== exp_instret()) begin
            n_fail++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret());
        end
    endtask

    task automatic test_store_branch();
        plan(OP_STORE, 0, 1);
        plan(OP_BRANCH, 1, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL st_br_step got=%b exp=%b", obs, s.exp); end
        end
        @(posedge clk); #1;
        n_checks++;
        if (instret !== exp_instret()) begin
            n_fail++; $display("FAIL st_br_instret got=%0d exp=%0d", instret, exp_instret());
        end
    endtask

    task automatic test_illegal();
        logic [6:0] bad;
        bad = 7'($urandom);
        while (is_legal_op(bad)) bad = 7'($urandom);
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            plan(OP_ADDI, 0, 0);
            plan((k == 0) ? OP_SYSTEM : bad, 1, 0);
            while (q.size() > 0) begin
                step_t s;
                s = q.pop_front();
                @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
                n_checks++;
                if (obs !== s.exp) begin n_fail++; $display("FAIL illegal_step op=%b got=%b exp=%b", op, obs, s.exp); end
            end
            @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
            n_checks++;
            if ((obs & STROBES) !== 11'd0) begin
                n_fail++; $display("FAIL trap_reset_strobes got=%b exp no strobes", obs);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            exp_retired = 0;
            n_checks++;
            if (state !== 3'd0 || trap !== 1'b0 || instret !== exp_instret()) begin
                n_fail++;
                $display("FAIL trap_reset state=%0d trap=%b instret=%0d exp 0/0/0", state, trap, instret);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        plan(OP_ADDI, TIMEOUT, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL fetch_timeout got=%b exp=%b", obs, s.exp); end
        end
        apply_reset();
        plan(OP_ADDI, TIMEOUT - 1, 0);
        plan(OP_STORE, TIMEOUT - 1, TIMEOUT - 1);
        plan(OP_LOAD, 0, TIMEOUT);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL limit_and_mem_timeout got=%b exp=%b", obs, s.exp); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(8, 0));
            plan(LEGAL_OPS[k], int'($urandom_range(TIMEOUT - 1, 0)), int'($urandom_range(TIMEOUT - 1, 0)));
            while (q.size() > 0) begin
                step_t s;
                s = q.pop_front();
                @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
                n_checks++;
                if (obs !== s.exp) begin n_fail++; $display("FAIL random_step n=%0d op=%b got=%b exp=%b", n, op, obs, s.exp); end
            end
            @(posedge clk); #1;
            n_checks++;
            if (instret !== exp_instret()) begin
                n_fail++; $display("FAIL random_instret n=%0d got=%0d exp=%0d", n, instret, exp_instret());
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 17; n++) plan(OP_ADDI, 0, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL wrap_step got=%b exp=%b", obs, s.exp); end
        end
        @(posedge clk); #1;
        n_checks++;
        if (instret !== exp_instret()) begin
            n_fail++; $display("FAIL wrap_instret got=%0d exp=%0d", instret, exp_instret());
        end
    endtask

    task automatic test_mid_mem_reset();
        apply_reset();
        plan(OP_STORE, 0, 3);
        repeat (3) void'(q.pop_back());
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk); op = s.op; mem_ready = s.rdy; #1;
            n_checks++;
            if (obs !== s.exp) begin n_fail++; $display("FAIL mid_mem_step got=%b exp=%b", obs, s.exp); end
        end
        @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
        n_checks++;
        if ((obs & STROBES) !== 11'd0) begin
            n_fail++; $display("FAIL mid_mem_reset_strobes got=%b exp no strobes", obs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_retired = 0;
        n_checks++;
        if (state !== 3'd0 || trap !== 1'b0 || instret !== exp_instret()) begin
            n_fail++; $display("FAIL mid_mem_reset_state state=%0d trap=%b instret=%0d exp 0/0/0", state, trap, instret);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store_branch();
        test_illegal();
        test_timeout();
        test_random();
        test_wrap();
        test_mid_mem_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
